// File: rtl/pipe_stage_regs_pkg.sv
// Shared definitions for the RV32I pipeline-register bank: control-bundle
// layout, result-select encodings and the bubble constants.
package pipe_stage_regs_pkg;

  // Control bundle: {RegWrite,ResultSrc[1:0],MemWrite,Jump,Branch,ALUSrc,ALUControl[2:0]}
  localparam int CTRL_W         = 10;
  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_RESSRC_HI = 8;
  localparam int CTRL_RESSRC_LO = 7;
  localparam int CTRL_MEMWRITE  = 6;
  localparam int CTRL_JUMP      = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_ALUSRC    = 3;

  typedef enum logic [1:0] {
    RESULTSRC_ALU  = 2'b00,
    RESULTSRC_LOAD = 2'b01,
    RESULTSRC_PC4  = 2'b10
  } result_src_e;

  localparam logic [31:0]       NOP_INSTR   = 32'h0000_0013;
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  // An empty decode slot must not leak its decoded controls into execute,
  // otherwise the NOP sitting in a bubble would look like a register write.
  function automatic logic [CTRL_W-1:0] mask_ctrl(input logic [CTRL_W-1:0] ctrl,
                                                  input logic              valid);
    return valid ? ctrl : BUBBLE_CTRL;
  endfunction

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Bundle of every pipeline-facing signal of the register bank. The core side
// (fetch mux, decoder, hazard unit) uses master; the register bank uses slave.
interface pipe_stage_regs_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = pipe_stage_regs_pkg::CTRL_W,
  parameter int CNT_W  = 32
);
  logic              StallF, StallD, FlushD, FlushE;
  logic [XLEN-1:0]   PCNextF, PCF;
  logic [31:0]       InstrF;
  logic [XLEN-1:0]   PCPlus4F;
  logic [31:0]       InstrD;
  logic [XLEN-1:0]   PCD, PCPlus4D;
  logic              ValidD;
  logic [CTRL_W-1:0] CtrlD;
  logic [4:0]        Rs1D, Rs2D, RdD;
  logic [CTRL_W-1:0] CtrlE;
  logic [4:0]        Rs1E, Rs2E, RdE;
  logic [XLEN-1:0]   PCE, PCPlus4E;
  logic [1:0]        ResultSrcE;
  logic              ValidE;
  logic              RegWriteM, MemWriteM;
  logic [1:0]        ResultSrcM;
  logic [4:0]        RdM;
  logic              RegWriteW;
  logic [1:0]        ResultSrcW;
  logic [4:0]        RdW;
  logic              ValidM, ValidW;
  logic              ctr_clr;
  logic [CNT_W-1:0]  cycle_cnt, retire_cnt, stall_cnt, flush_cnt;

  modport master (
    output StallF, StallD, FlushD, FlushE, PCNextF, InstrF, PCPlus4F,
           CtrlD, Rs1D, Rs2D, RdD, ctr_clr,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, CtrlE, Rs1E, Rs2E, RdE,
           PCE, PCPlus4E, ResultSrcE, ValidE, RegWriteM, MemWriteM,
           ResultSrcM, RdM, RegWriteW, ResultSrcW, RdW, ValidM, ValidW,
           cycle_cnt, retire_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE, PCNextF, InstrF, PCPlus4F,
           CtrlD, Rs1D, Rs2D, RdD, ctr_clr,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, CtrlE, Rs1E, Rs2E, RdE,
           PCE, PCPlus4E, ResultSrcE, ValidE, RegWriteM, MemWriteM,
           ResultSrcM, RdM, RegWriteW, ResultSrcW, RdW, ValidM, ValidW,
           cycle_cnt, retire_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_regs_reg.sv
// Generic stage register: clear loads the bubble value and beats enable,
// so a flush always wins over a stall.
module pipe_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // Bubble on reset or clear, otherwise capture when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_q <= RST_VAL;
    else if (i_clr) r_q <= RST_VAL;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_regs.sv
// Pipeline-register bank of the 5-stage RV32I core (PC, F/D, D/E, E/M, M/W)
// plus wrap-around performance counters.
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              CTRL_W   = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input logic              clk,
  input logic              rst_n,
  pipe_stage_regs_if.slave bus
);
  localparam int FD_W = 32 + 2*XLEN + 1;
  localparam int DE_W = CTRL_W + 15 + 2*XLEN + 1;
  localparam int EM_W = 10;
  localparam int MW_W = 9;
  localparam logic [FD_W-1:0]  FD_BUBBLE = {NOP_INSTR, {(2*XLEN+1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]   w_pcF;
  logic [FD_W-1:0]   w_fdQ;
  logic [31:0]       w_instrD;
  logic [XLEN-1:0]   w_pcD, w_pcPlus4D;
  logic              w_validD;
  logic [DE_W-1:0]   w_deQ;
  logic [CTRL_W-1:0] w_ctrlE;
  logic [4:0]        w_rs1E, w_rs2E, w_rdE;
  logic [XLEN-1:0]   w_pcE, w_pcPlus4E;
  logic              w_validE;
  logic [EM_W-1:0]   w_emQ;
  logic              w_regWriteM, w_memWriteM, w_validM;
  logic [1:0]        w_resultSrcM;
  logic [4:0]        w_rdM;
  logic [MW_W-1:0]   w_mwQ;
  logic              w_regWriteW, w_validW;
  logic [1:0]        w_resultSrcW;
  logic [4:0]        w_rdW;
  logic [CNT_W-1:0]  r_cycleCnt, r_retireCnt, r_stallCnt, r_flushCnt;

  pipe_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pcReg (
    .clk(clk), .rst_n(rst_n), .i_en(~bus.StallF), .i_clr(1'b0),
    .i_d(bus.PCNextF), .o_q(w_pcF));

  pipe_reg #(.W(FD_W), .RST_VAL(FD_BUBBLE)) u_fdReg (
    .clk(clk), .rst_n(rst_n), .i_en(~bus.StallD), .i_clr(bus.FlushD),
    .i_d({bus.InstrF, w_pcF, bus.PCPlus4F, 1'b1}), .o_q(w_fdQ));
  assign {w_instrD, w_pcD, w_pcPlus4D, w_validD} = w_fdQ;

  // An invalid decode slot enters execute as a clean bubble (no controls, no Rd)
  pipe_reg #(.W(DE_W), .RST_VAL('0)) u_deReg (
    .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(bus.FlushE),
    .i_d({mask_ctrl(bus.CtrlD, w_validD), bus.Rs1D, bus.Rs2D,
          (w_validD ? bus.RdD : 5'd0), w_pcD, w_pcPlus4D, w_validD}),
    .o_q(w_deQ));
  assign {w_ctrlE, w_rs1E, w_rs2E, w_rdE, w_pcE, w_pcPlus4E, w_validE} = w_deQ;

  pipe_reg #(.W(EM_W), .RST_VAL('0)) u_emReg (
    .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(1'b0),
    .i_d({w_ctrlE[CTRL_REGWRITE], w_ctrlE[CTRL_MEMWRITE],
          w_ctrlE[CTRL_RESSRC_HI:CTRL_RESSRC_LO], w_rdE, w_validE}),
    .o_q(w_emQ));
  assign {w_regWriteM, w_memWriteM, w_resultSrcM, w_rdM, w_validM} = w_emQ;

  pipe_reg #(.W(MW_W), .RST_VAL('0)) u_mwReg (
    .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(1'b0),
    .i_d({w_regWriteM, w_resultSrcM, w_rdM, w_validM}), .o_q(w_mwQ));
  assign {w_regWriteW, w_resultSrcW, w_rdW, w_validW} = w_mwQ;

  // Performance counters: clear beats increment, each wraps at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycleCnt  <= '0;
      r_retireCnt <= '0;
      r_stallCnt  <= '0;
      r_flushCnt  <= '0;
    end else if (bus.ctr_clr) begin
      r_cycleCnt  <= '0;
      r_retireCnt <= '0;
      r_stallCnt  <= '0;
      r_flushCnt  <= '0;
    end else begin
      r_cycleCnt <= r_cycleCnt + CNT_ONE;
      if (w_validW)                 r_retireCnt <= r_retireCnt + CNT_ONE;
      if (bus.StallD)               r_stallCnt  <= r_stallCnt + CNT_ONE;
      if (bus.FlushD || bus.FlushE) r_flushCnt  <= r_flushCnt + CNT_ONE;
    end
  end

  assign bus.PCF        = w_pcF;
  assign bus.InstrD     = w_instrD;
  assign bus.PCD        = w_pcD;
  assign bus.PCPlus4D   = w_pcPlus4D;
  assign bus.ValidD     = w_validD;
  assign bus.CtrlE      = w_ctrlE;
  assign bus.Rs1E       = w_rs1E;
  assign bus.Rs2E       = w_rs2E;
  assign bus.RdE        = w_rdE;
  assign bus.PCE        = w_pcE;
  assign bus.PCPlus4E   = w_pcPlus4E;
  assign bus.ResultSrcE = w_ctrlE[CTRL_RESSRC_HI:CTRL_RESSRC_LO];
  assign bus.ValidE     = w_validE;
  assign bus.RegWriteM  = w_regWriteM;
  assign bus.MemWriteM  = w_memWriteM;
  assign bus.ResultSrcM = w_resultSrcM;
  assign bus.RdM        = w_rdM;
  assign bus.ValidM     = w_validM;
  assign bus.RegWriteW  = w_regWriteW;
  assign bus.ResultSrcW = w_resultSrcW;
  assign bus.RdW        = w_rdW;
  assign bus.ValidW     = w_validW;
  assign bus.cycle_cnt  = r_cycleCnt;
  assign bus.retire_cnt = r_retireCnt;
  assign bus.stall_cnt  = r_stallCnt;
  assign bus.flush_cnt  = r_flushCnt;
endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed testbench for pipe_stage_regs. A tiny instruction memory and
// decoder stand in for the rest of the core; counters are 4 bits wide so
// the wrap-around is reachable quickly.
module tb_pipe_stage_regs;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [31:0] imem [16];

  pipe_stage_regs_if #(.XLEN(32), .CTRL_W(10), .CNT_W(4)) bus ();

  pipe_stage_regs #(.XLEN(32), .CTRL_W(10), .RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sequential fetch: next PC and PC+4 follow the current fetch PC
  assign bus.PCNextF  = bus.PCF + 32'd4;
  assign bus.PCPlus4F = bus.PCF + 32'd4;
  assign bus.InstrF   = imem[bus.PCF[5:2]];
  assign bus.Rs1D     = bus.InstrD[19:15];
  assign bus.Rs2D     = bus.InstrD[24:20];
  assign bus.RdD      = bus.InstrD[11:7];

  // Minimal decoder for the opcodes the program uses
  always_comb begin
    bus.CtrlD = '0;
    case (bus.InstrD[6:0])
      7'b0000011: bus.CtrlD = 10'b1_01_0_0_0_1_000;
      7'b0110011: bus.CtrlD = 10'b1_00_0_0_0_0_000;
      7'b0010011: bus.CtrlD = 10'b1_00_0_0_0_1_000;
      default:    bus.CtrlD = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.StallF = 0; bus.StallD = 0; bus.FlushD = 0; bus.FlushE = 0; bus.ctr_clr = 0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.PCF !== 32'h0) begin errors++; $display("[TB] FAIL rst_pcf got=%h exp=%h", bus.PCF, 32'h0); end
    checks++; if (bus.InstrD !== 32'h13) begin errors++; $display("[TB] FAIL rst_instrd got=%h exp=%h", bus.InstrD, 32'h13); end
    checks++; if (bus.ValidD !== 1'b0) begin errors++; $display("[TB] FAIL rst_validd got=%b exp=0", bus.ValidD); end
    checks++; if (bus.CtrlE !== 10'h0) begin errors++; $display("[TB] FAIL rst_ctrle got=%h exp=0", bus.CtrlE); end
    checks++; if (bus.RdW !== 5'd0 || bus.RegWriteW !== 1'b0) begin errors++; $display("[TB] FAIL rst_w got rd=%0d rw=%b exp rd=0 rw=0", bus.RdW, bus.RegWriteW); end
    checks++; if (bus.cycle_cnt !== 4'h0 || bus.retire_cnt !== 4'h0) begin errors++; $display("[TB] FAIL rst_cnt got cyc=%h ret=%h exp 0", bus.cycle_cnt, bus.retire_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    tick(); // edge 1
    checks++; if (bus.PCF !== 32'h4) begin errors++; $display("[TB] FAIL seq_pcf1 got=%h exp=%h", bus.PCF, 32'h4); end
    checks++; if (bus.InstrD !== 32'h93 || bus.ValidD !== 1'b1) begin errors++; $display("[TB] FAIL seq_instrd1 got=%h/%b exp=00000093/1", bus.InstrD, bus.ValidD); end
    checks++; if (bus.PCD !== 32'h0 || bus.PCPlus4D !== 32'h4) begin errors++; $display("[TB] FAIL seq_pcd1 got=%h/%h exp=0/4", bus.PCD, bus.PCPlus4D); end
    tick(); // edge 2
    checks++; if (bus.PCF !== 32'h8) begin errors++; $display("[TB] FAIL seq_pcf2 got=%h exp=%h", bus.PCF, 32'h8); end
    checks++; if (bus.RdE !== 5'd1 || bus.ValidE !== 1'b1 || bus.CtrlE !== 10'h208) begin errors++; $display("[TB] FAIL seq_e2 got rd=%0d v=%b ctrl=%h exp 1/1/208", bus.RdE, bus.ValidE, bus.CtrlE); end
    checks++; if (bus.PCE !== 32'h0 || bus.PCPlus4E !== 32'h4) begin errors++; $display("[TB] FAIL seq_pce2 got=%h/%h exp=0/4", bus.PCE, bus.PCPlus4E); end
    tick(); // edge 3
    checks++; if (bus.RdM !== 5'd1 || bus.RegWriteM !== 1'b1 || bus.ValidM !== 1'b1) begin errors++; $display("[TB] FAIL seq_m3 got rd=%0d rw=%b v=%b exp 1/1/1", bus.RdM, bus.RegWriteM, bus.ValidM); end
    tick(); // edge 4
    checks++; if (bus.RdW !== 5'd1 || bus.RegWriteW !== 1'b1 || bus.ValidW !== 1'b1) begin errors++; $display("[TB] FAIL seq_w4 got rd=%0d rw=%b v=%b exp 1/1/1", bus.RdW, bus.RegWriteW, bus.ValidW); end
    checks++; if (bus.retire_cnt !== 4'd0 || bus.cycle_cnt !== 4'd4) begin errors++; $display("[TB] FAIL seq_cnt4 got ret=%0d cyc=%0d exp 0/4", bus.retire_cnt, bus.cycle_cnt); end
    tick(); // edge 5
    checks++; if (bus.retire_cnt !== 4'd1 || bus.RdW !== 5'd2) begin errors++; $display("[TB] FAIL seq_ret5 got ret=%0d rdw=%0d exp 1/2", bus.retire_cnt, bus.RdW); end
  endtask

  task automatic test_load_use();
    tick(); tick(); tick(); // edges 6..8: lw in E, add in D
    checks++; if (bus.InstrD !== 32'h0012_8333) begin errors++; $display("[TB] FAIL lu_instrd8 got=%h exp=00128333", bus.InstrD); end
    checks++; if (bus.RdE !== 5'd5 || bus.ResultSrcE !== 2'b01) begin errors++; $display("[TB] FAIL lu_e8 got rd=%0d rs=%b exp 5/01", bus.RdE, bus.ResultSrcE); end
    bus.StallF = 1; bus.StallD = 1; bus.FlushE = 1;
    tick(); // edge 9
    bus.StallF = 0; bus.StallD = 0; bus.FlushE = 0;
    checks++; if (bus.PCF !== 32'h20 || bus.InstrD !== 32'h0012_8333) begin errors++; $display("[TB] FAIL lu_hold9 got pc=%h instr=%h exp 20/00128333", bus.PCF, bus.InstrD); end
    checks++; if (bus.ValidE !== 1'b0 || bus.CtrlE !== 10'h0 || bus.RdE !== 5'd0) begin errors++; $display("[TB] FAIL lu_bubble9 got v=%b ctrl=%h rd=%0d exp 0/0/0", bus.ValidE, bus.CtrlE, bus.RdE); end
    checks++; if (bus.RdM !== 5'd5) begin errors++; $display("[TB] FAIL lu_m9 got=%0d exp=5", bus.RdM); end
    checks++; if (bus.stall_cnt !== 4'd1 || bus.flush_cnt !== 4'd1) begin errors++; $display("[TB] FAIL lu_cnt9 got st=%0d fl=%0d exp 1/1", bus.stall_cnt, bus.flush_cnt); end
    tick(); // edge 10
    checks++; if (bus.RdE !== 5'd6 || bus.Rs1E !== 5'd5 || bus.Rs2E !== 5'd1 || bus.ValidE !== 1'b1) begin errors++; $display("[TB] FAIL lu_e10 got rd=%0d rs1=%0d rs2=%0d v=%b exp 6/5/1/1", bus.RdE, bus.Rs1E, bus.Rs2E, bus.ValidE); end
    checks++; if (bus.RdM !== 5'd0 || bus.RegWriteM !== 1'b0 || bus.RdW !== 5'd5) begin errors++; $display("[TB] FAIL lu_mw10 got rdm=%0d rwm=%b rdw=%0d exp 0/0/5", bus.RdM, bus.RegWriteM, bus.RdW); end
    checks++; if (bus.PCF !== 32'h24) begin errors++; $display("[TB] FAIL lu_pcf10 got=%h exp=24", bus.PCF); end
  endtask

  task automatic test_flush();
    bus.ctr_clr = 1;
    tick(); // edge 11
    bus.ctr_clr = 0;
    checks++; if (bus.cycle_cnt !== 4'd0 || bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0 || bus.retire_cnt !== 4'd0) begin errors++; $display("[TB] FAIL fl_clr11 got %0d/%0d/%0d/%0d exp 0", bus.cycle_cnt, bus.stall_cnt, bus.flush_cnt, bus.retire_cnt); end
    bus.FlushD = 1; bus.FlushE = 1; bus.StallD = 1;
    tick(); // edge 12
    bus.FlushD = 0; bus.FlushE = 0; bus.StallD = 0;
    checks++; if (bus.ValidD !== 1'b0 || bus.InstrD !== 32'h13) begin errors++; $display("[TB] FAIL fl_d12 got v=%b instr=%h exp 0/00000013", bus.ValidD, bus.InstrD); end
    checks++; if (bus.ValidE !== 1'b0 || bus.RdE !== 5'd0) begin errors++; $display("[TB] FAIL fl_e12 got v=%b rd=%0d exp 0/0", bus.ValidE, bus.RdE); end
    checks++; if (bus.PCF !== 32'h2C || bus.RdM !== 5'd9) begin errors++; $display("[TB] FAIL fl_pc12 got pc=%h rdm=%0d exp 2c/9", bus.PCF, bus.RdM); end
    checks++; if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd1 || bus.cycle_cnt !== 4'd1) begin errors++; $display("[TB] FAIL fl_cnt12 got fl=%0d st=%0d cyc=%0d exp 1/1/1", bus.flush_cnt, bus.stall_cnt, bus.cycle_cnt); end
    tick(); // edge 13
    checks++; if (bus.RegWriteM !== 1'b0 || bus.RdM !== 5'd0) begin errors++; $display("[TB] FAIL fl_m13 got rw=%b rd=%0d exp 0/0", bus.RegWriteM, bus.RdM); end
    checks++; if (bus.ValidE !== 1'b0 || bus.CtrlE !== 10'h0) begin errors++; $display("[TB] FAIL fl_e13 got v=%b ctrl=%h exp 0/0", bus.ValidE, bus.CtrlE); end
    checks++; if (bus.ValidD !== 1'b1 || bus.InstrD !== 32'h613) begin errors++; $display("[TB] FAIL fl_d13 got v=%b instr=%h exp 1/00000613", bus.ValidD, bus.InstrD); end
  endtask

  task automatic test_counter_wrap();
    bus.ctr_clr = 1;
    tick(); // edge 14
    bus.ctr_clr = 0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (bus.cycle_cnt !== 4'hF) begin errors++; $display("[TB] FAIL cw_full got=%h exp=f", bus.cycle_cnt); end
    tick();
    checks++; if (bus.cycle_cnt !== 4'h0) begin errors++; $display("[TB] FAIL cw_wrap got=%h exp=0", bus.cycle_cnt); end
    checks++; if (bus.ValidW !== 1'b1) begin errors++; $display("[TB] FAIL cw_validw got=%b exp=1", bus.ValidW); end
    bus.ctr_clr = 1;
    tick();
    bus.ctr_clr = 0;
    checks++; if (bus.retire_cnt !== 4'h0 || bus.cycle_cnt !== 4'h0) begin errors++; $display("[TB] FAIL cw_clrwins got ret=%h cyc=%h exp 0/0", bus.retire_cnt, bus.cycle_cnt); end
    tick();
    checks++; if (bus.retire_cnt !== 4'h1 || bus.cycle_cnt !== 4'h1) begin errors++; $display("[TB] FAIL cw_resume got ret=%h cyc=%h exp 1/1", bus.retire_cnt, bus.cycle_cnt); end
  endtask

  task automatic test_async_reset();
    #3;
    checks++; if ({bus.ValidD, bus.ValidE, bus.ValidM, bus.ValidW} !== 4'b1111) begin errors++; $display("[TB] FAIL ar_pre got=%b exp=1111", {bus.ValidD, bus.ValidE, bus.ValidM, bus.ValidW}); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.PCF !== 32'h0) begin errors++; $display("[TB] FAIL ar_pcf got=%h exp=0", bus.PCF); end
    checks++; if ({bus.ValidD, bus.ValidE, bus.ValidM, bus.ValidW} !== 4'b0000) begin errors++; $display("[TB] FAIL ar_valid got=%b exp=0000", {bus.ValidD, bus.ValidE, bus.ValidM, bus.ValidW}); end
    checks++; if (bus.RegWriteW !== 1'b0 || bus.RdW !== 5'd0) begin errors++; $display("[TB] FAIL ar_w got rw=%b rd=%0d exp 0/0", bus.RegWriteW, bus.RdW); end
    checks++; if (bus.InstrD !== 32'h13 || bus.cycle_cnt !== 4'h0) begin errors++; $display("[TB] FAIL ar_misc got instr=%h cyc=%h exp 00000013/0", bus.InstrD, bus.cycle_cnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int k = 0; k < 16; k++) imem[k] = {12'd0, 5'd0, 3'b000, 5'(k + 1), 7'b0010011};
    imem[6] = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    imem[7] = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'b0110011};
    test_reset();
    test_sequential();
    test_load_use();
    test_flush();
    test_counter_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
